// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM duty meter and its tenths divider.
package pwm_pkg;
  localparam int DUTY_W = 4;
  localparam logic [DUTY_W-1:0] DUTY_STEPS = 4'd10;

  typedef enum logic {IDLE = 1'b0, MEAS = 1'b1} meas_state_e;
endpackage

// File: rtl/pwm_duty_div.sv
// Iterative tenths divider: k = floor(10*high/period), one step per cycle, done on the k+1-th cycle.
module pwm_duty_div
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              start,
  input  logic [CNT_W-1:0]  period,
  input  logic [CNT_W-1:0]  high,
  output logic              busy,
  output logic              done,
  output logic [DUTY_W-1:0] k
);
  localparam int ACC_W = CNT_W + 4;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] per;
  logic [ACC_W-1:0] h10;
  logic [ACC_W-1:0] acc_nxt;
  logic             step;

  function automatic logic [ACC_W-1:0] times_ten(input logic [CNT_W-1:0] x);
    logic [ACC_W-1:0] xe;
    xe = {4'b0000, x};
    return (xe << 3) + (xe << 1);
  endfunction

  assign acc_nxt = acc + per;
  assign step    = (k < DUTY_STEPS) && (acc_nxt <= h10);
  assign done    = busy && !step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      k    <= '0;
    end else if (clr) begin
      busy <= 1'b0;
      k    <= '0;
    end else if (start) begin
      busy <= 1'b1;
      k    <= '0;
    end else if (busy) begin
      if (step) k <= k + 1'b1;
      else      busy <= 1'b0;
    end
  end

  // operand/accumulator registers carry no reset; busy qualifies them
  always_ff @(posedge clk) begin
    if (start) begin
      acc <= '0;
      per <= {4'b0000, period};
      h10 <= times_ten(high);
    end else if (busy && step) begin
      acc <= acc_nxt;
    end
  end
endmodule

// File: rtl/pwm_duty_meter.sv
// Measures period and high time of a PWM input and reports duty in tenths, with static-input timeout.
module pwm_duty_meter
  import pwm_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic [DUTY_W-1:0] duty_tenths,
  output logic              meas_valid,
  output logic              timeout,
  output logic              meas_drop
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, s_d, rise;
  meas_state_e            state_q, state_d;
  logic [CNT_W-1:0]       period_cnt, high_cnt;
  logic                   snap, to_hit;
  logic                   pend_vld;
  logic [CNT_W-1:0]       pend_per, pend_high;
  logic                   div_start, div_clr, div_busy, div_done;
  logic [CNT_W-1:0]       div_per, div_high;
  logic [DUTY_W-1:0]      div_k;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == CNT_MAX) ? x : x + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d    <= s;
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign rise   = s && !s_d;
  assign snap   = ena && (state_q == MEAS) && rise;
  assign to_hit = ena && (state_q == MEAS) && !rise && (period_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!ena) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (rise) state_d = MEAS;
        MEAS:    if (to_hit) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // the rise cycle itself counts as the first cycle of the new period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (!ena || to_hit) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (rise) begin
      period_cnt <= CNT_W'(1);
      high_cnt   <= CNT_W'(1);
    end else if (state_q == MEAS) begin
      period_cnt <= sat_inc(period_cnt);
      if (s) high_cnt <= sat_inc(high_cnt);
    end
  end

  assign div_clr   = !ena || to_hit;
  assign div_start = ena && !div_busy && (pend_vld || snap);
  assign div_per   = pend_vld ? pend_per  : period_cnt;
  assign div_high  = pend_vld ? pend_high : high_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               pend_vld <= 1'b0;
    else if (div_clr)         pend_vld <= 1'b0;
    else if (snap)            pend_vld <= div_busy || pend_vld;
    else if (!div_busy)       pend_vld <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (snap && (div_busy || pend_vld)) begin
      pend_per  <= period_cnt;
      pend_high <= high_cnt;
    end
  end

  pwm_duty_div #(.CNT_W(CNT_W)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (div_clr),
    .start  (div_start),
    .period (div_per),
    .high   (div_high),
    .busy   (div_busy),
    .done   (div_done),
    .k      (div_k)
  );

  // timeout takes priority over any divider result in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period      <= '0;
      high_time   <= '0;
      duty_tenths <= '0;
      meas_valid  <= 1'b0;
      timeout     <= 1'b0;
      meas_drop   <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      meas_drop  <= 1'b0;
      if (to_hit) begin
        timeout     <= 1'b1;
        period      <= '0;
        high_time   <= '0;
        duty_tenths <= s ? DUTY_STEPS : '0;
        meas_valid  <= 1'b1;
      end else if (ena) begin
        if (snap) begin
          period    <= period_cnt;
          high_time <= high_cnt;
        end
        if (div_done) begin
          duty_tenths <= div_k;
          meas_valid  <= 1'b1;
          timeout     <= 1'b0;
        end
        meas_drop <= snap && div_busy && pend_vld;
      end
    end
  end
endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter at CNT_W=8, SYNC_STAGES=2.
module tb_pwm_duty_meter;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic             pwm_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic [3:0]       duty_tenths;
  logic             meas_valid;
  logic             timeout;
  logic             meas_drop;

  int cyc = 0;
  int n_chk = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_drop = 0;
  int rise_q[$];
  int valid_q[$];
  int v0, d0, ri, vi;

  pwm_duty_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .pwm_in      (pwm_in),
    .period      (period),
    .high_time   (high_time),
    .duty_tenths (duty_tenths),
    .meas_valid  (meas_valid),
    .timeout     (timeout),
    .meas_drop   (meas_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (meas_valid === 1'b1) begin
        n_valid <= n_valid + 1;
        valid_q.push_back(cyc);
      end
      if (meas_drop === 1'b1) n_drop <= n_drop + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  function automatic int vq(input int i);
    return (i < valid_q.size()) ? valid_q[i] : -1;
  endfunction

  function automatic int rq(input int i);
    return (i < rise_q.size()) ? rise_q[i] : -100;
  endfunction

  task automatic set_pwm(input logic v);
    if (v && !pwm_in) rise_q.push_back(cyc);
    pwm_in = v;
  endtask

  task automatic drive(input int per, input int hi, input int nper);
    for (int p = 0; p < nper; p++)
      for (int i = 0; i < per; i++) begin
        @(negedge clk);
        set_pwm(i < hi);
      end
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_pwm(v);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_period", 32'(period), 0);
    chk("rst_high", 32'(high_time), 0);
    chk("rst_duty", 32'(duty_tenths), 0);
    chk("rst_valid", 32'(meas_valid), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_drop", 32'(meas_drop), 0);
    rst_n = 1'b1;

    hold(1'b0, 200);
    chk("idle_valid", 32'(n_valid), 0);
    chk("idle_timeout", 32'(timeout), 0);

    // 50% at period 10: valid 3 sync cycles + 6 divider cycles after the second rise
    ri = rise_q.size(); vi = valid_q.size(); d0 = n_drop;
    drive(10, 5, 6);
    chk("p10_latency", 32'(vq(vi)), 32'(rq(ri + 1) + 9));
    chk("p10_rate", 32'(vq(vi + 1) - vq(vi)), 10);
    chk("p10_period", 32'(period), 10);
    chk("p10_high", 32'(high_time), 5);
    chk("p10_duty", 32'(duty_tenths), 5);
    chk("p10_nodrop", 32'(n_drop - d0), 0);

    drive(10, 1, 4);
    chk("h1_duty", 32'(duty_tenths), 1);
    chk("h1_high", 32'(high_time), 1);
    drive(10, 9, 4);
    chk("h9_duty", 32'(duty_tenths), 9);
    chk("h9_high", 32'(high_time), 9);
    drive(20, 19, 3);
    chk("h19_duty", 32'(duty_tenths), 9);
    chk("h19_period", 32'(period), 20);

    v0 = n_valid;
    hold(1'b0, 300);
    chk("lo_timeout", 32'(timeout), 1);
    chk("lo_duty", 32'(duty_tenths), 0);
    chk("lo_period", 32'(period), 0);
    chk("lo_nvalid", 32'(n_valid - v0), 1);

    v0 = n_valid;
    hold(1'b1, 300);
    chk("hi_timeout", 32'(timeout), 1);
    chk("hi_duty", 32'(duty_tenths), 10);
    chk("hi_period", 32'(period), 0);
    chk("hi_highr", 32'(high_time), 0);
    chk("hi_nvalid", 32'(n_valid - v0), 1);

    drive(10, 5, 4);
    chk("resume_timeout", 32'(timeout), 0);
    chk("resume_duty", 32'(duty_tenths), 5);
    chk("resume_period", 32'(period), 10);

    // 8-cycle divide against 4-cycle snapshots
    d0 = n_drop;
    drive(4, 3, 10);
    chk("p4_duty", 32'(duty_tenths), 7);
    chk("p4_period", 32'(period), 4);
    chk("p4_high", 32'(high_time), 3);
    chk("p4_dropped", 32'(n_drop > d0), 1);

    drive(7, 3, 4);
    d0 = n_drop;
    drive(7, 3, 5);
    chk("p7_duty", 32'(duty_tenths), 4);
    chk("p7_period", 32'(period), 7);
    chk("p7_nodrop", 32'(n_drop - d0), 0);

    // reset while the 10/9 divide is still running
    drive(10, 9, 2);
    chk("prerst_period", 32'(period), 10);
    chk("prerst_high", 32'(high_time), 9);
    rst_n = 1'b0;
    #1;
    chk("mrst_period", 32'(period), 0);
    chk("mrst_high", 32'(high_time), 0);
    chk("mrst_duty", 32'(duty_tenths), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    v0 = n_valid;
    hold(1'b0, 30);
    chk("mrst_novalid", 32'(n_valid - v0), 0);

    drive(10, 5, 4);
    chk("preena_duty", 32'(duty_tenths), 5);
    @(negedge clk);
    ena = 1'b0;
    v0 = n_valid;
    drive(10, 2, 4);
    chk("enalo_duty", 32'(duty_tenths), 5);
    chk("enalo_period", 32'(period), 10);
    chk("enalo_high", 32'(high_time), 5);
    chk("enalo_novalid", 32'(n_valid - v0), 0);

    ri = rise_q.size(); vi = valid_q.size();
    @(negedge clk);
    ena = 1'b1;
    drive(10, 2, 4);
    chk("reena_latency", 32'(vq(vi)), 32'(rq(ri + 1) + 6));
    chk("reena_duty", 32'(duty_tenths), 2);
    chk("reena_high", 32'(high_time), 2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/pwm_duty_meter.md
Name: pwm_duty_meter

Overview:
- Downstream consumer of the PWM generator output. Measures the period and high time of a single-bit PWM input and reports the duty cycle in 10% steps (0..10).
- Detects a static input (0% / 100%) by timeout.
- Used as on-chip self-check / readback of the generated PWM, and as a general PWM capture stage.

Parameters:
CNT_W, 16, width of period/high-time counters; timeout threshold is 2^CNT_W-1 cycles
SYNC_STAGES, 2, synchronizer flops on pwm_in (min 2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  measurement enable; low = FSM held in IDLE, counters cleared, outputs hold
pwm_in  in  1  PWM signal (asynchronous to clk tolerated)
period  out  CNT_W  last measured period, clk cycles
high_time  out  CNT_W  last measured high time, clk cycles
duty_tenths  out  4  floor(10*high_time/period), range 0..10
meas_valid  out  1  one-cycle pulse when duty_tenths updates
timeout  out  1  level: no rising edge seen for 2^CNT_W-1 cycles
meas_drop  out  1  one-cycle pulse when a pending snapshot is overwritten

Behaviour:
- Reset:
  - period, high_time, duty_tenths = 0; meas_valid, timeout, meas_drop = 0; FSM = IDLE.
  - Reset is async-assert; asserting it mid-calc discards all state.
- Input path:
  - SYNC_STAGES flops give s; one extra flop gives s_d; rise = s & ~s_d.
  - pwm_in rise to rise-cycle latency is SYNC_STAGES+1 clocks.
- FSM states:
  - IDLE: counters idle. First rise -> MEAS, period_cnt=1, high_cnt=1.
  - MEAS: period_cnt +1 every cycle (saturating); high_cnt +1 on cycles with s=1.
    - On rise: snapshot (period_cnt, high_cnt) to period/high_time outputs on the same edge, then reload period_cnt=1, high_cnt=1.
    - If period_cnt reaches 2^CNT_W-1 without a rise -> timeout handling, return to IDLE.
- Counting semantics: the edge cycle counts as 1. Example: 10-cycle PWM, 5 high -> period=10, high_time=5.
- Duty calculation: performed by the divider sub-module from the snapshot.
  - Init: acc=0, k=0. Each cycle: if k<10 and acc+period <= 10*high, then acc+=period and k++; else finish.
  - Internal width CNT_W+4, so there is no overflow.
  - Latency: k+1 cycles after start.
  - At finish: duty_tenths=k, meas_valid pulses in that cycle, timeout cleared.
- Busy divider:
  - A snapshot arriving while the divider is busy goes to a one-entry pending register; it starts the cycle after finish.
  - A second snapshot while pending is full overwrites it and pulses meas_drop.
  - period/high_time outputs always update immediately, regardless of divider state.
- Timeout:
  - timeout=1; period=0, high_time=0.
  - duty_tenths = 10 if s=1, else 0; meas_valid pulses.
  - Divider and pending register are flushed. The next measurement needs a rise plus one full period.
- Simultaneous events:
  - Rise in the same cycle as saturation: rise wins, no timeout.
  - Rise in the same cycle as divider finish: finish completes, new snapshot starts on the next cycle (no drop).
- ena low:
  - FSM forced to IDLE; divider and pending are flushed.
  - Outputs hold; timeout holds.
  - Synchronizer keeps running.

Decomposition:
- Shared package pwm_pkg: DUTY_STEPS=10, FSM state enum (IDLE, MEAS), duty width constant 4.
- Sub-module pwm_duty_div: iterative tenths divider.
  - Inputs: start, period, high. Outputs: busy, done, k.
  - Top level holds the sync, counters, FSM, pending register and timeout.

Test Plan (CNT_W=8, SYNC_STAGES=2):
1. rst_n=0 then release, pwm_in=0 -> all outputs 0, no meas_valid for 200 cycles.
2. pwm_in period 10, high 5 (driven from the PWM generator at reset duty) -> first snapshot on the second rise: period=10, high_time=5. meas_valid 6 cycles later with duty_tenths=5, then repeats every 10 cycles, meas_drop never asserts.
3. Duty sweep, period 10 with high 1, 9, 10-1 boundary -> duty_tenths 1, 9, 9. Then high 0 and high 10 (static) -> timeout after 255 cycles with duty 0 and 10 respectively.
4. pwm_in held 1 for 300 cycles -> timeout=1, period=0, high_time=0, duty_tenths=10, single meas_valid. Resume period-10 PWM -> timeout clears at the next meas_valid.
5. Period 4, high 3 -> duty 7 (7.5 floored). Calc takes 8 cycles versus a 4-cycle snapshot rate, so meas_drop pulses periodically while period/high_time update every 4 cycles. Period 7, high 3 -> duty 4, no drops.
6. rst_n asserted mid-calc and ena deasserted mid-measure -> async clear of everything on reset. With ena low, outputs hold and the next valid arrives only after re-enable plus two rises.
